serial_product_capture: RTL and testbench

//  Downstream stage of the bit-serial carry-save adder chain in the serial-parallel multiplier.
//  It collects the LSB-first serial product stream into a PROD_W-bit parallel word.
//  It presents that word on a valid/ready handshake, and can apply backpressure to the next capture.

---
 rtl/serial_product_capture_if.sv | 14 +
 rtl/serial_product_capture.sv | 78 +++++++
 tb/tb_serial_product_capture.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_product_capture_if.sv
// serial_product_capture_if: serial product stream in, parallel product handshake out.
interface serial_product_capture_if #(
    parameter int PROD_W = 16
);
    logic              start;
    logic              sum_in;
    logic              out_ready;
    logic              out_valid;
    logic [PROD_W-1:0] product;
    logic              busy;
    logic              overrun;
    modport master (output start, sum_in, out_ready, input out_valid, product, busy, overrun);
    modport slave  (input start, sum_in, out_ready, output out_valid, product, busy, overrun);
endinterface

// File: rtl/serial_product_capture.sv
// serial_product_capture: gathers an LSB-first serial product into a parallel word
// and offers it on a valid/ready handshake, flagging starts that arrive while busy.
module serial_product_capture #(
    parameter int PROD_W = 16,
    parameter int LEAD   = 1
) (
    input logic                    clk,
    input logic                    rst,
    serial_product_capture_if.slave bus
);
    localparam int MX = (LEAD > PROD_W) ? LEAD : PROD_W;
    localparam int CW = $clog2(MX) + 1;
    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, HOLD} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PROD_W-2:0] sr_q, sr_d;
    logic [PROD_W-1:0] prod_q, prod_d, nxt;
    logic              valid_q, valid_d, ovr_q, ovr_d, xfer, accept;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            prod_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end
    // The shift register keeps only the newest PROD_W-1 bits; the final bit joins on completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        prod_d  = prod_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        nxt     = {bus.sum_in, sr_q};
        xfer    = (state_q == HOLD) && valid_q && bus.out_ready;
        accept  = bus.start && ((state_q == IDLE) || xfer);
        case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q == '0) state_d = SHIFT;
                else cnt_d = cnt_q - 1'b1;
            end
            SHIFT: begin
                sr_d = nxt[PROD_W-1:1];
                if (cnt_q == CW'(PROD_W - 1)) begin
                    prod_d  = nxt;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else cnt_d = cnt_q + 1'b1;
            end
            HOLD: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
        if (accept) begin
            state_d = (LEAD == 0) ? SHIFT : WAIT;
            cnt_d   = (LEAD == 0) ? '0 : CW'(LEAD - 1);
        end
        if (bus.start && !accept) ovr_d = 1'b1;
    end
    assign bus.out_valid = valid_q;
    assign bus.product   = prod_q;
    assign bus.busy      = (state_q == WAIT) || (state_q == SHIFT);
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_serial_product_capture.sv
// tb_serial_product_capture: directed vectors on a 16-bit/LEAD=1 instance and an 8-bit/LEAD=0 instance.
module tb_serial_product_capture;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    serial_product_capture_if #(.PROD_W(16)) a ();
    serial_product_capture_if #(.PROD_W(8))  b ();
    serial_product_capture #(.PROD_W(16), .LEAD(1)) u_a (.clk(clk), .rst(rst), .bus(a));
    serial_product_capture #(.PROD_W(8),  .LEAD(0)) u_b (.clk(clk), .rst(rst), .bus(b));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] vld(input int sel);
        return sel != 0 ? 32'(b.out_valid) : 32'(a.out_valid);
    endfunction
    function automatic logic [31:0] bsy(input int sel);
        return sel != 0 ? 32'(b.busy) : 32'(a.busy);
    endfunction
    function automatic logic [31:0] ovr(input int sel);
        return sel != 0 ? 32'(b.overrun) : 32'(a.overrun);
    endfunction
    function automatic logic [31:0] prd(input int sel);
        return sel != 0 ? 32'(b.product) : 32'(a.product);
    endfunction
    task automatic drv(input int sel, input logic s, input logic d, input logic r);
        if (sel != 0) begin
            b.start = s; b.sum_in = d; b.out_ready = r;
        end else begin
            a.start = s; a.sum_in = d; a.out_ready = r;
        end
    endtask
    // Full capture: start (optionally with out_ready for a back-to-back transfer), LEAD idle cycles, w bits.
    task automatic cap(input int sel, input logic [15:0] val, input int w, input int lead,
                       input logic rdy, input int pb);
        drv(sel, 1'b1, 1'b0, rdy);
        @(negedge clk);
        chk("vld_start", vld(sel), 0);
        chk("busy_start", bsy(sel), 1);
        drv(sel, 1'b0, 1'b0, 1'b0);
        repeat (lead) @(negedge clk);
        for (int k = 0; k < w; k++) begin
            drv(sel, k == pb, val[k], 1'b0);
            @(negedge clk);
            if (k == 0) chk("busy_shift", bsy(sel), 1);
            if (k == w - 2) chk("vld_early", vld(sel), 0);
        end
        drv(sel, 1'b0, 1'b0, 1'b0);
        chk("vld_done", vld(sel), 1);
        chk("prod", prd(sel), 32'(val) & ((32'd1 << w) - 1));
        chk("busy_hold", bsy(sel), 0);
    endtask
    initial begin
        logic [15:0] v;
        drv(0, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_prod", prd(0), 0);
        chk("rst_vld", vld(0), 0);
        chk("rst_busy", bsy(0), 0);
        chk("rst_ovr", ovr(0), 0);
        rst = 1'b1;
        @(negedge clk);
        cap(0, 16'h1234, 16, 1, 1'b0, -1);
        for (int c = 0; c < 5; c++) begin
            drv(0, c == 2, 1'b0, 1'b0);
            @(negedge clk);
            chk("bp_vld", vld(0), 1);
            chk("bp_prod", prd(0), 32'h1234);
        end
        drv(0, 1'b0, 1'b0, 1'b0);
        chk("bp_ovr", ovr(0), 1);
        chk("bp_busy", bsy(0), 0);
        drv(0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 1'b0);
        chk("xfer_vld", vld(0), 0);
        chk("xfer_prod", prd(0), 32'h1234);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_ovr", ovr(0), 0);
        rst = 1'b1;
        @(negedge clk);
        cap(0, 16'hFFFF, 16, 1, 1'b0, -1);
        cap(0, 16'h0001, 16, 1, 1'b1, -1);
        chk("b2b_ovr", ovr(0), 0);
        v = 16'hBEEF;
        drv(0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            drv(0, 1'b0, v[k], 1'b0);
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_prod", prd(0), 0);
        chk("arst_vld", vld(0), 0);
        chk("arst_busy", bsy(0), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cap(0, 16'hA5A5, 16, 1, 1'b0, -1);
        cap(0, 16'h5A3C, 16, 1, 1'b1, 4);
        chk("shift_ovr", ovr(0), 1);
        drv(0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("ovr_sticky", ovr(0), 1);
        chk("idle_vld", vld(0), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst3_ovr", ovr(0), 0);
        rst = 1'b1;
        @(negedge clk);
        cap(1, 16'h00C3, 8, 0, 1'b0, -1);
        chk("b_ovr", ovr(1), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
